// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory port arbiter: funct3 encodings for
// byte/half/word accesses, the arbiter state enum, the byte-lane count and a
// helper that tells whether a funct3 code is legal for a load or a store.
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int NUM_LANES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RDATA = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Stores only have signed-width encodings; unsigned variants are load-only.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok_v;
      ok_v = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok_v = 1'b1;
         F3_BU, F3_HU:     ok_v = ~is_store;
         default:          ok_v = 1'b0;
      endcase
      return ok_v;
   endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// -----------------------------------------------------------------------------
// dmem_lane_steer
// Purely combinational byte-lane steering for a 4-lane data memory.
//   funct3     in  3   access size / signedness
//   addr_lo    in  2   byte offset within the word
//   wdata      in  32  raw store data
//   mem_rdata  in  32  raw word read from memory
//   we_mask    out 4   byte-lane write enables for a store of this size
//   wdata_rep  out 32  store data replicated across the lanes
//   load_data  out 32  selected lane, sign/zero-extended
//   misalign   out 1   half/word access not naturally aligned
// -----------------------------------------------------------------------------
module dmem_lane_steer
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  we_mask,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [31:0] shifted_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Bring the addressed byte down to lane 0; halfwords use addr bit 1 only.
   assign shifted_s = mem_rdata >> {addr_lo, 3'b000};
   assign byte_s    = shifted_s[7:0];
   assign half_s    = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   // Decode size into lane mask, store replication, load extension and alignment.
   always_comb begin
      we_mask   = 4'b0000;
      wdata_rep = 32'h0000_0000;
      load_data = 32'h0000_0000;
      misalign  = 1'b0;
      case (funct3)
         F3_B: begin
            we_mask   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            load_data = {{24{byte_s[7]}}, byte_s};
         end
         F3_H: begin
            we_mask   = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
            load_data = {{16{half_s[15]}}, half_s};
            misalign  = addr_lo[0];
         end
         F3_W: begin
            we_mask   = 4'b1111;
            wdata_rep = wdata;
            load_data = mem_rdata;
            misalign  = (addr_lo != 2'b00);
         end
         F3_BU: begin
            load_data = {24'h00_0000, byte_s};
         end
         F3_HU: begin
            load_data = {16'h0000, half_s};
            misalign  = addr_lo[0];
         end
         default: begin
            we_mask   = 4'b0000;
            wdata_rep = 32'h0000_0000;
            load_data = 32'h0000_0000;
            misalign  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares a 4-bank byte-lane data memory between the load/store unit (port 0)
// and the auxiliary/debug loader (port 1). Round-robin arbitration, one
// transaction in flight, access checking done at accept time so a bad access
// never strobes the memory.
//   clk, reset   in        clock, synchronous active-high reset
//   req_valid    in  2     per-port request valid
//   req_ready    out 2     one-hot grant, only in IDLE
//   req_we       in  2     1 = store
//   req_addr     in  64    byte address, port i at [i*32 +: 32]
//   req_wdata    in  64    store data, port i at [i*32 +: 32]
//   req_funct3   in  6     funct3, port i at [i*3 +: 3]
//   rsp_valid    out 2     one-cycle response strobe per port
//   rsp_rdata    out 32    load result (0 for stores/errors)
//   rsp_err      out 1     access error
//   mem_addr     out DM_ADDRESS-2  word address
//   mem_we       out 4     byte-lane write enables
//   mem_wdata    out 32    lane-replicated store data
//   mem_re       out 1     read strobe
//   mem_rdata    in  32    read data, one cycle after mem_re
// -----------------------------------------------------------------------------
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_we,
   input  logic [2*DATA_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   input  logic [5:0]            req_funct3,
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic [DM_ADDRESS-3:0] mem_addr,
   output logic [NUM_LANES-1:0]  mem_we,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_re,
   input  logic [DATA_W-1:0]     mem_rdata
);

   state_e                 state_r, next_state_s;
   logic                   rr_ptr_r;
   logic                   port_r;
   logic                   we_r;
   logic [1:0]             addr_lo_r;
   logic [2:0]             funct3_r;
   logic                   err_r;

   logic                   grant_valid_s;
   logic                   grant_s;
   logic                   sel_we_s;
   logic [DATA_W-1:0]      sel_addr_s;
   logic [DATA_W-1:0]      sel_wdata_s;
   logic [2:0]             sel_f3_s;
   logic                   acc_err_s;

   logic [2:0]             st_f3_s;
   logic [1:0]             st_addr_lo_s;
   logic [3:0]             st_we_mask_s;
   logic [DATA_W-1:0]      st_wdata_rep_s;
   logic [DATA_W-1:0]      st_load_s;
   logic                   st_misalign_s;

   logic [DM_ADDRESS-3:0]  mem_addr_r;
   logic [NUM_LANES-1:0]   mem_we_r;
   logic [DATA_W-1:0]      mem_wdata_r;
   logic                   mem_re_r;
   logic [1:0]             rsp_valid_r;
   logic [DATA_W-1:0]      rsp_rdata_r;
   logic                   rsp_err_r;

   // Arbitration: sole requester wins, ties go to the round-robin pointer.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
      if ((state_r == IDLE) && !reset) begin
         case (req_valid)
            2'b01: begin grant_valid_s = 1'b1; grant_s = 1'b0;     end
            2'b10: begin grant_valid_s = 1'b1; grant_s = 1'b1;     end
            2'b11: begin grant_valid_s = 1'b1; grant_s = rr_ptr_r; end
            default: begin grant_valid_s = 1'b0; grant_s = 1'b0;   end
         endcase
      end else begin
         grant_valid_s = 1'b0;
         grant_s       = 1'b0;
      end
   end

   assign req_ready   = grant_valid_s ? (2'b01 << grant_s) : 2'b00;

   assign sel_we_s    = grant_s ? req_we[1]                 : req_we[0];
   assign sel_addr_s  = grant_s ? req_addr[2*DATA_W-1:DATA_W]  : req_addr[DATA_W-1:0];
   assign sel_wdata_s = grant_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
   assign sel_f3_s    = grant_s ? req_funct3[5:3]           : req_funct3[2:0];

   // The single steering block sees the incoming request while idle (store
   // lanes, alignment) and the latched request otherwise (load extension).
   assign st_f3_s      = (state_r == IDLE) ? sel_f3_s        : funct3_r;
   assign st_addr_lo_s = (state_r == IDLE) ? sel_addr_s[1:0] : addr_lo_r;

   dmem_lane_steer u_steer (
      .funct3    (st_f3_s),
      .addr_lo   (st_addr_lo_s),
      .wdata     (sel_wdata_s),
      .mem_rdata (mem_rdata),
      .we_mask   (st_we_mask_s),
      .wdata_rep (st_wdata_rep_s),
      .load_data (st_load_s),
      .misalign  (st_misalign_s)
   );

   assign acc_err_s = (|sel_addr_s[DATA_W-1:DM_ADDRESS])
                    | ~f3_legal(sel_we_s, sel_f3_s)
                    | st_misalign_s;

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) next_state_s = ISSUE;
            else               next_state_s = IDLE;
         end
         ISSUE: begin
            if (!err_r && !we_r) next_state_s = RDATA;
            else                 next_state_s = RESP;
         end
         RDATA:   next_state_s = RESP;
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State, request latch and registered outputs. Memory strobes are loaded at
   // accept so they are live exactly during ISSUE; responses are loaded on the
   // edge into RESP so they are live exactly during RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         rr_ptr_r    <= 1'b0;
         port_r      <= 1'b0;
         we_r        <= 1'b0;
         addr_lo_r   <= 2'b00;
         funct3_r    <= 3'b000;
         err_r       <= 1'b0;
         mem_addr_r  <= '0;
         mem_we_r    <= 4'b0000;
         mem_wdata_r <= '0;
         mem_re_r    <= 1'b0;
         rsp_valid_r <= 2'b00;
         rsp_rdata_r <= '0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         mem_addr_r  <= '0;
         mem_we_r    <= 4'b0000;
         mem_wdata_r <= '0;
         mem_re_r    <= 1'b0;
         rsp_valid_r <= 2'b00;
         rsp_rdata_r <= '0;
         rsp_err_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  port_r     <= grant_s;
                  we_r       <= sel_we_s;
                  addr_lo_r  <= sel_addr_s[1:0];
                  funct3_r   <= sel_f3_s;
                  err_r      <= acc_err_s;
                  rr_ptr_r   <= ~grant_s;
                  mem_addr_r <= sel_addr_s[DM_ADDRESS-1:2];
                  if (!acc_err_s && sel_we_s) begin
                     mem_we_r    <= st_we_mask_s;
                     mem_wdata_r <= st_wdata_rep_s;
                  end else if (!acc_err_s) begin
                     mem_re_r    <= 1'b1;
                  end else begin
                     mem_re_r    <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               if (next_state_s == RESP) begin
                  rsp_valid_r <= 2'b01 << port_r;
                  rsp_err_r   <= err_r;
               end
            end
            RDATA: begin
               rsp_valid_r <= 2'b01 << port_r;
               rsp_rdata_r <= st_load_s;
            end
            RESP: begin
               rsp_valid_r <= 2'b00;
            end
            default: begin
               rsp_valid_r <= 2'b00;
            end
         endcase
      end
   end

   assign mem_addr  = mem_addr_r;
   assign mem_we    = mem_we_r;
   assign mem_wdata = mem_wdata_r;
   assign mem_re    = mem_re_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter with a small behavioural data memory.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [5:0]  req_funct3;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [6:0]  mem_addr;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata;
   logic        mem_re;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata)
   );

   // Behavioural 128-word byte-lane memory with one-cycle read latency.
   logic [31:0] mem_q [0:127];
   logic [31:0] rd_q;
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) mem_q[i] <= 32'h0;
         rd_q <= 32'h0;
      end else begin
         for (int l = 0; l < 4; l++)
            if (mem_we[l]) mem_q[mem_addr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
         if (mem_re) rd_q <= mem_q[mem_addr];
      end
   end
   assign mem_rdata = rd_q;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3);
      req_we[p]            = we;
      req_addr[p*32 +: 32] = addr;
      req_wdata[p*32 +: 32]= wd;
      req_funct3[p*3 +: 3] = f3;
      req_valid[p]         = 1'b1;
   endtask

   // One full transaction on port p; returns sampling inside the RESP cycle.
   task automatic txn(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [3:0] e_we, input logic [31:0] e_wd,
                      input logic e_re, input logic [31:0] e_rd, input logic e_err);
      int n;
      drive(p, we, addr, wd, f3);
      #1;
      n = 0;
      while (req_ready[p] !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("req_ready", req_ready, 2'b01 << p);
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("c1_mem_we",    mem_we,    e_we);
      chk("c1_mem_re",    mem_re,    e_re);
      chk("c1_mem_addr",  mem_addr,  addr[8:2]);
      chk("c1_rsp_valid", rsp_valid, 2'b00);
      if (e_we != 4'b0000) chk("c1_mem_wdata", mem_wdata, e_wd);
      @(posedge clk); #1;
      if (e_re) begin
         chk("c2_rsp_valid", rsp_valid, 2'b00);
         chk("c2_mem_re",    mem_re,    1'b0);
         @(posedge clk); #1;
      end
      chk("rsp_valid", rsp_valid, 2'b01 << p);
      chk("rsp_err",   rsp_err,   e_err);
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("rsp_mem_strobes", {mem_we, mem_re}, 5'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset      = 1'b1;
      req_valid  = 2'b00;
      req_we     = 2'b00;
      req_addr   = 64'h0;
      req_wdata  = 64'h0;
      req_funct3 = 6'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 37'h0);
      chk("reset_mem", {mem_addr, mem_we, mem_re, mem_wdata}, 44'h0);
      reset = 1'b0;

      // Stores and loads with lane steering / extension.
      txn(0, 1'b1, 32'h13, 32'h123456AB, F3_B, 4'b1000, 32'hABABABAB, 1'b0, 32'h0, 1'b0);
      txn(0, 1'b1, 32'h20, 32'h80017FFF, F3_W, 4'b1111, 32'h80017FFF, 1'b0, 32'h0, 1'b0);
      txn(0, 1'b0, 32'h22, 32'h0, F3_H,  4'b0000, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
      txn(0, 1'b0, 32'h22, 32'h0, F3_HU, 4'b0000, 32'h0, 1'b1, 32'h00008001, 1'b0);
      txn(0, 1'b0, 32'h20, 32'h0, F3_B,  4'b0000, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0);
      txn(0, 1'b0, 32'h21, 32'h0, F3_BU, 4'b0000, 32'h0, 1'b1, 32'h0000007F, 1'b0);
      txn(0, 1'b0, 32'h10, 32'h0, F3_W,  4'b0000, 32'h0, 1'b1, 32'hAB000000, 1'b0);
      txn(1, 1'b1, 32'h32, 32'h1234BEEF, F3_H, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0, 1'b0);
      txn(1, 1'b0, 32'h30, 32'h0, F3_W,  4'b0000, 32'h0, 1'b1, 32'hBEEF0000, 1'b0);

      // Misaligned, out-of-range and illegal funct3: no strobes, error response.
      txn(0, 1'b1, 32'h6,   32'hDEADBEEF, F3_W,   4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);
      txn(0, 1'b0, 32'h3,   32'h0,        F3_H,   4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);
      txn(1, 1'b1, 32'h200, 32'hDEADBEEF, F3_W,   4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);
      txn(0, 1'b1, 32'h20,  32'h55555555, 3'b100, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);
      txn(1, 1'b0, 32'h20,  32'h0,        3'b011, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);
      txn(1, 1'b0, 32'h20,  32'h0,        F3_W,   4'b0000, 32'h0, 1'b1, 32'h80017FFF, 1'b0);

      // Both ports continuously valid from reset: grants alternate 0,1,0,1.
      reset = 1'b1;
      drive(0, 1'b1, 32'h40, 32'h11, F3_B);
      drive(1, 1'b1, 32'h44, 32'h22, F3_B);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (req_ready === 2'b00 && n < 20) begin
            @(posedge clk); #1; n++;
         end
         chk("rr_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
         @(posedge clk); #1;
         chk("rr_mem_addr", mem_addr, (k % 2 == 1) ? 7'h11 : 7'h10);
         chk("rr_busy_ready", req_ready, 2'b00);
         @(posedge clk); #1;
         chk("rr_rsp_valid", rsp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
         @(posedge clk); #1;
      end
      req_valid = 2'b00;

      // Reset during ISSUE of a port 1 load drops it; port 0 then wins first.
      drive(1, 1'b0, 32'h20, 32'h0, F3_W);
      #1;
      n = 0;
      while (req_ready[1] !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("rst_ready", req_ready, 2'b10);
      @(posedge clk); #1;
      chk("rst_issue_re", mem_re, 1'b1);
      reset = 1'b1;
      drive(0, 1'b1, 32'h40, 32'h11, F3_B);
      drive(1, 1'b1, 32'h44, 32'h22, F3_B);
      @(posedge clk); #1;
      chk("rst_abort_re",  mem_re,    1'b0);
      chk("rst_abort_rsp", rsp_valid, 2'b00);
      @(posedge clk); #1;
      chk("rst_no_rsp", rsp_valid, 2'b00);
      reset = 1'b0;
      #1;
      chk("rst_grant_p0", req_ready, 2'b01);
      @(posedge clk); #1;
      chk("rst2_issue_we", mem_we, 4'b0001);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst2_abort_we",  mem_we,    4'b0000);
      chk("rst2_abort_rsp", rsp_valid, 2'b00);
      reset = 1'b0;
      #1;
      chk("rst2_grant_p0", req_ready, 2'b01);
      req_valid = 2'b00;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the 4-bank byte-lane data memory between two requesters: port 0 is the pipeline load/store unit and port 1 is the auxiliary/debug loader.
- Handles fair arbitration and one outstanding transaction at a time.
- Steers store bytes and byte-enables from funct3 and the address, and aligns and sign/zero-extends load data.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- DM_ADDRESS, 9: byte-address width of the data memory. Word address is addr[DM_ADDRESS-1:2].
- DATA_W, 32: data width. Fixed at 32; 4 byte lanes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  request valid, bit i = port i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_we  in  2  1 = store, 0 = load
- req_addr  in  64  byte address, port i at [i*32 +: 32]
- req_wdata  in  64  store data, port i at [i*32 +: 32]
- req_funct3  in  6  funct3, port i at [i*3 +: 3]
- rsp_valid  out  2  one-cycle response strobe per port
- rsp_rdata  out  32  load result (0 for stores and errors)
- rsp_err  out  1  access error, qualified by rsp_valid
- mem_addr  out  DM_ADDRESS-2  word address to memory
- mem_we  out  4  byte-lane write enables
- mem_wdata  out  32  lane-replicated store data
- mem_re  out  1  read strobe
- mem_rdata  in  32  read data, valid the cycle after mem_re

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: all outputs 0, state IDLE, round-robin pointer rr_ptr = 0.
- FSM states: IDLE, ISSUE, RDATA, RESP.
- IDLE, arbitration:
  - Grant goes to the sole valid port; if both are valid, to port rr_ptr.
  - req_ready[g] = 1 combinationally in IDLE only.
  - On accept: register port, we, addr, wdata and funct3; set rr_ptr = ~g; go to ISSUE.
- Error check, performed at accept and registered:
  - Error if req_addr[31:DM_ADDRESS] != 0.
  - Error if funct3 is illegal. Legal stores: 000, 001, 010. Legal loads: 000, 001, 010, 100, 101.
  - Error if misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- ISSUE:
  - No error and store: mem_we asserted.
    - SB: mem_we = 0001<<addr[1:0], mem_wdata = {4{wdata[7:0]}}.
    - SH: mem_we = 0011<<{addr[1],1'b0}, mem_wdata = {2{wdata[15:0]}}.
    - SW: mem_we = 1111, mem_wdata = wdata.
    - Next state RESP.
  - No error and load: mem_re = 1, next state RDATA.
  - Error: no mem_we or mem_re, next state RESP.
  - mem_addr = addr[DM_ADDRESS-1:2] in ISSUE; 0 otherwise.
- RDATA:
  - Select the lane of mem_rdata using addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register the result; go to RESP.
- RESP:
  - rsp_valid[port] = 1 for exactly one cycle with rsp_rdata and rsp_err.
  - Next state IDLE. There is no response backpressure; requesters must sink the response.
- Latency from accept cycle 0:
  - Store or error: memory strobe at cycle 1, rsp_valid at cycle 2.
  - Load: mem_re at cycle 1, rsp_valid at cycle 3.
  - Next accept is possible in the cycle after RESP.
- Outstanding transactions: at most one. A port holding req_valid during another port's transaction waits in IDLE arbitration.
- mem_we and mem_re are never asserted together, and never outside ISSUE.
- Reset mid-transaction: the state machine aborts to IDLE on the next edge. No further mem strobes, the response is dropped, and rr_ptr returns to 0.
- req_* inputs are ignored outside IDLE; changes while not ready have no effect.

Decomposition:
- dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, ISSUE, RDATA, RESP.
  - Lane-count constant.
- Sub-module dmem_lane_steer: purely combinational. Inputs funct3, addr[1:0], wdata and mem_rdata; outputs we mask, replicated wdata, extended load data and the misalign flag. The arbiter instantiates it once.

Test Plan:
- Port 0 SB, addr 0x13, wdata 0x123456AB → cycle 1: mem_we=1000, mem_addr=4, mem_wdata=0xABABABAB. Cycle 2: rsp_valid=01, err=0, rdata=0.
- Port 0 SW 0x80017FFF at 0x20, then loads from 0x20–0x22 → LH 0x22 gives 0xFFFF8001; LHU 0x22 gives 0x00008001; LB 0x20 gives 0xFFFFFFFF; LBU 0x21 gives 0x0000007F. Each load: rsp_valid at cycle 3.
- Misaligned SW at 0x6, LH at 0x3, and SW at 0x200 (DM_ADDRESS=9) → no mem_we or mem_re ever asserted; rsp_err=1 at cycle 2.
- Both ports hold req_valid continuously from reset with SB requests → grant order 0,1,0,1. Each port's response is on its own rsp_valid bit; never two outstanding.
- Illegal funct3: store 100 and load 011 → rsp_err=1, memory untouched. A following legal LW from port 1 returns the correct data.
- Reset asserted during ISSUE of a port 1 load → next cycle mem_re=0, no rsp_valid ever. With both ports then valid, port 0 is granted first.
